hm_nonce_controller: RTL and testbench
======================================

// Module: hm_nonce_controller
// PURPOSE
//  Sequences the nonce search for one block header. Issues nonces one at a time to the SHA-256 hash core,
//  waits for hash_done, and samples the check-hash valid flag. It then stops on a valid hash, on
//  reaching stop_nonce, on abort, or on a hash-core timeout. Sits between the top-level miner control and
//  the hash core / hash checker pair.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in WAIT without hash_done before ERROR (>=2)
//  CNT_W           32   width of hash_count (saturating)
// PORTS
//  clk              in   1       system clock, all logic rising-edge
//  n_rst            in   1       synchronous active-low reset
//  start            in   1       1-cycle request: begin a search (accepted in IDLE/FOUND/EXHAUSTED/ERROR only)
//  abort            in   1       return to IDLE from any state; has priority over start
//  start_nonce      in   32      first nonce, latched on accepted start
//  stop_nonce       in   32      last nonce (inclusive), latched on accepted start
//  hash_done        in   1       hash core finished the current nonce
//  valid_hash_flag  in   1       checker result; only meaningful when hash_done=1
//  hash_start       out  1       1-cycle pulse: hash core loads nonce_out
//  nonce_out        out  32      nonce under test; stable from hash_start until hash_done
//  busy             out  1       1 in ISSUE/WAIT
//  found            out  1       sticky: valid hash found
//  exhausted        out  1       sticky: range finished without a valid hash
//  timeout_err      out  1       sticky: hash core failed to respond
//  golden_nonce     out  32      nonce that produced the valid hash
//  hash_count       out  CNT_W   hash_done events accepted this run; saturates at all-ones
// BEHAVIOUR
//  Reset (n_rst=0 at clk edge): state=IDLE; all outputs 0, incl. nonce_out, golden_nonce, hash_count.
//  States: IDLE, ISSUE, WAIT, FOUND, EXHAUSTED, ERROR. Outputs are registered or decoded from state only.
//  IDLE/FOUND/EXHAUSTED/ERROR + start (abort=0):
//    - nonce<=start_nonce; limit<=stop_nonce; hash_count<=0
//    - clear found/exhausted/timeout_err; ->ISSUE
//  ISSUE: hash_start=1 for exactly this cycle; wait timer<=0; ->WAIT.
//  WAIT, hash_done=1 (first match wins):
//    1) valid_hash_flag=1 -> golden_nonce<=nonce; found<=1; ->FOUND
//    2) nonce==limit -> exhausted<=1; ->EXHAUSTED
//    3) otherwise nonce<=nonce+1 (mod 2^32, FFFFFFFF wraps to 0); ->ISSUE
//    All three cases increment hash_count.
//  WAIT, hash_done=0: timer++. Timer reaching TIMEOUT_CYCLES-1 with no hash_done -> timeout_err<=1; ->ERROR.
//  Latency:
//    - start sampled at edge N -> hash_start high in cycle N+1.
//    - hash_done sampled at edge M -> next hash_start in cycle M+1.
//    - found/exhausted visible in cycle M+1.
//  Range: start_nonce==stop_nonce gives exactly one hash. stop<start wraps through 0.
//  Full 2^32 range: stop=start-1.
//  hash_done outside WAIT is ignored (no count, no state change). start while busy is ignored.
//  abort in any state -> IDLE next cycle:
//    - hash_start=0; busy=0; found/exhausted/timeout_err cleared
//    - golden_nonce and hash_count retained
//    - a hash_done arriving after abort is ignored
//  abort and start in the same cycle: abort wins and start is dropped.
//  Reset mid-search: same as power-on reset; in-flight hash result is discarded.
// TESTING
//  T1 reset: hold n_rst=0 2 cycles with start=1, hash_done=1 -> all outputs 0, state IDLE.
//  T2 find: start=0x10, stop=0x13; core answers 4 cycles after each hash_start; valid on 3rd done
//     -> hash_start pulses with nonce_out 0x10,0x11,0x12; found=1, golden_nonce=0x12, hash_count=3.
//  T3 exhaust: start=5, stop=7, valid never -> 3 hashes; exhausted=1, found=0, nonce_out=7, hash_count=3.
//  T4 wrap: start=0xFFFFFFFE, stop=0x00000001 -> nonces FFFFFFFE,FFFFFFFF,0,1; exhausted=1, hash_count=4.
//  T5 timeout: TIMEOUT_CYCLES=16, no hash_done -> timeout_err=1 after 16 WAIT cycles;
//     a later hash_done leaves hash_count=0.
//  T6 abort/overlap: start, then start again mid-WAIT (ignored), abort during WAIT
//     -> IDLE next cycle, busy=0; following hash_done ignored; new start runs a clean search from its start_nonce.

Source files
------------

// File: rtl/hm_nonce_controller.sv
// Nonce search sequencer: issues nonces to the hash core one at a time and stops
// on a valid hash, end of range, abort, or a hash-core timeout.
module hm_nonce_controller #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      start_nonce,
    input  logic [31:0]      stop_nonce,
    input  logic             hash_done,
    input  logic             valid_hash_flag,
    output logic             hash_start,
    output logic [31:0]      nonce_out,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             timeout_err,
    output logic [31:0]      golden_nonce,
    output logic [CNT_W-1:0] hash_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_FOUND     = 3'd3;
    localparam logic [2:0] S_EXHAUSTED = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;

    localparam int            TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      nonce_q, nonce_d;
    logic [31:0]      limit_q, limit_d;
    logic [31:0]      golden_q, golden_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TW-1:0]    timer_q, timer_d;

    always_comb begin
        state_d  = state_q;
        nonce_d  = nonce_q;
        limit_d  = limit_q;
        golden_d = golden_q;
        count_d  = count_q;
        timer_d  = timer_q;
        if (abort) begin
            // golden nonce and count survive an abort so software can still read them
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
                    if (start) begin
                        nonce_d = start_nonce;
                        limit_d = stop_nonce;
                        count_d = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (hash_done) begin
                        if (count_q != {CNT_W{1'b1}})
                            count_d = count_q + CNT_W'(1);
                        if (valid_hash_flag) begin
                            golden_d = nonce_q;
                            state_d  = S_FOUND;
                        end else if (nonce_q == limit_q) begin
                            state_d = S_EXHAUSTED;
                        end else begin
                            nonce_d = nonce_q + 32'd1;
                            state_d = S_ISSUE;
                        end
                    end else if (timer_q == TMAX) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            nonce_q  <= '0;
            limit_q  <= '0;
            golden_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            nonce_q  <= nonce_d;
            limit_q  <= limit_d;
            golden_q <= golden_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
        end
    end

    // Status flags are pure state decodes, so abort/start clear them for free
    assign hash_start   = (state_q == S_ISSUE);
    assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign found        = (state_q == S_FOUND);
    assign exhausted    = (state_q == S_EXHAUSTED);
    assign timeout_err  = (state_q == S_ERROR);
    assign nonce_out    = nonce_q;
    assign golden_nonce = golden_q;
    assign hash_count   = count_q;

endmodule

// File: tb/tb_hm_nonce_controller.sv
// Directed bench for hm_nonce_controller: reset, find, exhaust, wrap, timeout, abort.
module tb_hm_nonce_controller;

    logic        clk = 1'b0;
    logic        n_rst, start, abort, hash_done, valid_hash_flag;
    logic [31:0] start_nonce, stop_nonce;
    logic        hash_start, busy, found, exhausted, timeout_err;
    logic [31:0] nonce_out, golden_nonce;
    logic [31:0] hash_count;

    int n_asserts = 0;
    int n_fails   = 0;

    hm_nonce_controller #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .start_nonce(start_nonce), .stop_nonce(stop_nonce),
        .hash_done(hash_done), .valid_hash_flag(valid_hash_flag),
        .hash_start(hash_start), .nonce_out(nonce_out), .busy(busy),
        .found(found), .exhausted(exhausted), .timeout_err(timeout_err),
        .golden_nonce(golden_nonce), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; afterwards we sit in the first ISSUE cycle
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        start_nonce = a; stop_nonce = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Hash core model: answers 4 cycles after the hash_start it sees
    task automatic serve(input logic v, output logic [31:0] n);
        int k = 0;
        while (hash_start !== 1'b1 && k < 50) begin tick(); k++; end
        n_asserts++;
        if (k >= 50) begin
            n_fails++;
            $display("FAIL serve_wait: hash_start=%b, required 1 within 50 cycles", hash_start);
            n = 'x;
            return;
        end
        n = nonce_out;
        tick(); tick(); tick();
        hash_done = 1'b1; valid_hash_flag = v;
        tick();
        hash_done = 1'b0; valid_hash_flag = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b1; hash_done = 1'b1; abort = 1'b0;
        valid_hash_flag = 1'b1; start_nonce = 32'h55; stop_nonce = 32'h66;
        tick(); tick();
        n_asserts++;
        if ({hash_start, busy, found, exhausted, timeout_err} !== 5'b0 ||
            nonce_out !== 32'h0 || golden_nonce !== 32'h0 || hash_count !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_outputs: hs=%b busy=%b f=%b e=%b t=%b nonce=%h gold=%h cnt=%0d, required all 0",
                     hash_start, busy, found, exhausted, timeout_err, nonce_out, golden_nonce, hash_count);
        end
        start = 1'b0; hash_done = 1'b0; valid_hash_flag = 1'b0;
        n_rst = 1'b1;
        tick();
        n_asserts++;
        if (busy !== 1'b0 || hash_start !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_idle: busy=%b hs=%b, required 0 0", busy, hash_start);
        end
    endtask

    task automatic test_find();
        logic [31:0] n [3];
        logic [31:0] exp_n [3] = '{32'h10, 32'h11, 32'h12};
        do_start(32'h10, 32'h13);
        n_asserts++;
        if (hash_start !== 1'b1 || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL find_start_latency: hs=%b busy=%b, required 1 1", hash_start, busy);
        end
        serve(1'b0, n[0]);
        n_asserts++;
        if (hash_start !== 1'b1) begin
            n_fails++;
            $display("FAIL find_reissue_latency: hs=%b, required 1", hash_start);
        end
        serve(1'b0, n[1]);
        serve(1'b1, n[2]);
        for (int i = 0; i < 3; i++) begin
            n_asserts++;
            if (n[i] !== exp_n[i]) begin
                n_fails++;
                $display("FAIL find_nonce%0d: got %h, required %h", i, n[i], exp_n[i]);
            end
        end
        n_asserts++;
        if (found !== 1'b1 || busy !== 1'b0 || exhausted !== 1'b0 ||
            golden_nonce !== 32'h12 || hash_count !== 32'd3) begin
            n_fails++;
            $display("FAIL find_result: found=%b busy=%b exh=%b gold=%h cnt=%0d, required 1 0 0 00000012 3",
                     found, busy, exhausted, golden_nonce, hash_count);
        end
    endtask

    task automatic test_exhaust();
        logic [31:0] n;
        do_start(32'h5, 32'h7);
        n_asserts++;
        if (found !== 1'b0 || hash_count !== 32'd0) begin
            n_fails++;
            $display("FAIL exhaust_clear: found=%b cnt=%0d, required 0 0", found, hash_count);
        end
        for (int i = 0; i < 3; i++) begin
            serve(1'b0, n);
            n_asserts++;
            if (n !== 32'h5 + 32'(i)) begin
                n_fails++;
                $display("FAIL exhaust_nonce%0d: got %h, required %h", i, n, 32'h5 + 32'(i));
            end
        end
        n_asserts++;
        if (exhausted !== 1'b1 || found !== 1'b0 || nonce_out !== 32'h7 ||
            hash_count !== 32'd3 || hash_start !== 1'b0) begin
            n_fails++;
            $display("FAIL exhaust_result: exh=%b found=%b nonce=%h cnt=%0d hs=%b, required 1 0 00000007 3 0",
                     exhausted, found, nonce_out, hash_count, hash_start);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] n;
        logic [31:0] exp_n [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        do_start(32'hFFFFFFFE, 32'h00000001);
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, n);
            n_asserts++;
            if (n !== exp_n[i]) begin
                n_fails++;
                $display("FAIL wrap_nonce%0d: got %h, required %h", i, n, exp_n[i]);
            end
        end
        n_asserts++;
        if (exhausted !== 1'b1 || hash_count !== 32'd4) begin
            n_fails++;
            $display("FAIL wrap_result: exh=%b cnt=%0d, required 1 4", exhausted, hash_count);
        end
    endtask

    task automatic test_timeout();
        do_start(32'h40, 32'h50);
        for (int i = 0; i < 16; i++) tick();
        n_asserts++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL timeout_early: terr=%b busy=%b, required 0 1", timeout_err, busy);
        end
        tick();
        n_asserts++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_flag: terr=%b busy=%b, required 1 0", timeout_err, busy);
        end
        hash_done = 1'b1; valid_hash_flag = 1'b1;
        tick();
        hash_done = 1'b0; valid_hash_flag = 1'b0;
        tick();
        n_asserts++;
        if (hash_count !== 32'd0 || timeout_err !== 1'b1 || found !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_late_done: cnt=%0d terr=%b found=%b, required 0 1 0",
                     hash_count, timeout_err, found);
        end
    endtask

    task automatic test_abort_overlap();
        logic [31:0] n;
        do_start(32'h100, 32'h1FF);
        serve(1'b0, n);
        tick();
        do_start(32'h500, 32'h5FF);
        n_asserts++;
        if (busy !== 1'b1 || nonce_out !== 32'h101 || hash_start !== 1'b0) begin
            n_fails++;
            $display("FAIL overlap_ignore: busy=%b nonce=%h hs=%b, required 1 00000101 0",
                     busy, nonce_out, hash_start);
        end
        abort = 1'b1; start = 1'b1; start_nonce = 32'h900;
        tick();
        abort = 1'b0; start = 1'b0;
        n_asserts++;
        if (busy !== 1'b0 || hash_start !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0 ||
            timeout_err !== 1'b0 || hash_count !== 32'd1 || golden_nonce !== 32'h12) begin
            n_fails++;
            $display("FAIL abort_state: busy=%b hs=%b f=%b e=%b t=%b cnt=%0d gold=%h, required 0 0 0 0 0 1 00000012",
                     busy, hash_start, found, exhausted, timeout_err, hash_count, golden_nonce);
        end
        hash_done = 1'b1; valid_hash_flag = 1'b1;
        tick();
        hash_done = 1'b0; valid_hash_flag = 1'b0;
        tick();
        n_asserts++;
        if (hash_count !== 32'd1 || found !== 1'b0 || busy !== 1'b0 || golden_nonce !== 32'h12) begin
            n_fails++;
            $display("FAIL abort_late_done: cnt=%0d found=%b busy=%b gold=%h, required 1 0 0 00000012",
                     hash_count, found, busy, golden_nonce);
        end
        do_start(32'h20, 32'h20);
        serve(1'b1, n);
        n_asserts++;
        if (n !== 32'h20 || found !== 1'b1 || golden_nonce !== 32'h20 || hash_count !== 32'd1) begin
            n_fails++;
            $display("FAIL abort_restart: nonce=%h found=%b gold=%h cnt=%0d, required 00000020 1 00000020 1",
                     n, found, golden_nonce, hash_count);
        end
    endtask

    initial begin
        test_reset();
        test_find();
        test_exhaust();
        test_wrap();
        test_timeout();
        test_abort_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
